// File: rtl/led_fader.sv
// led_fader: LED output stage. Each of four channels ramps its brightness
// toward led_q[i] ? max_level : 0 on a slow fade tick. The brightness is
// rendered as 8-bit PWM on a registered output. Bypass mode drives the
// registered raw pattern instead, and the ramps keep running in the
// background.
module led_fader #(
  parameter int FADE_TICK_CYCLES = 50_000,
  parameter int FADE_STEP        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  led_in,
  input  logic [7:0]  max_level,
  input  logic        bypass,
  output logic [3:0]  led_out,
  output logic [31:0] level
);

  // A single-cycle tick period still needs a 1-bit counter.
  localparam int              CNT_W     = (FADE_TICK_CYCLES > 1) ? $clog2(FADE_TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(FADE_TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [8:0]       STEP9     = 9'(FADE_STEP);

  // One fade step from cur toward tgt. The arithmetic is 9 bits wide so
  // that the sum can never wrap. The result is clamped to the target, so
  // the level can never overshoot it.
  function automatic logic [7:0] fade_next(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] up_sum;
    logic [8:0] dn_gap;
    up_sum    = 9'd0;
    dn_gap    = 9'd0;
    fade_next = cur;
    if (cur < tgt) begin
      up_sum    = {1'b0, cur} + STEP9;
      fade_next = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[7:0];
    end else if (cur > tgt) begin
      dn_gap    = {1'b0, cur} - {1'b0, tgt};
      fade_next = (dn_gap <= STEP9) ? tgt : (cur - STEP9[7:0]);
    end else begin
      fade_next = cur;
    end
  endfunction

  // PWM compare for one channel. Full scale is forced on, because a
  // strict compare against an 8-bit counter can never reach 256/256.
  function automatic logic pwm_bit(input logic [7:0] lvl, input logic [7:0] cnt);
    if (lvl == 8'd255) begin
      pwm_bit = 1'b1;
    end else begin
      pwm_bit = (cnt < lvl);
    end
  endfunction

  logic [3:0]       r_led_q;
  logic             r_bypass_q;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [7:0]       r_pwm_cnt;
  logic [3:0][7:0]  r_level;
  logic [3:0]       r_led_out;

  logic             w_tick;
  logic [3:0][7:0]  w_target;
  logic [3:0][7:0]  w_level_next;
  logic [3:0]       w_pwm_out;
  logic [3:0]       w_out_next;

  // Register the pattern and the bypass select from the generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led_q    <= 4'b0000;
      r_bypass_q <= 1'b0;
    end else begin
      r_led_q    <= led_in;
      r_bypass_q <= bypass;
    end
  end

  // Fade tick divider. It counts 0..FADE_TICK_CYCLES-1 and then wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CNT_ONE;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Free-running 8-bit PWM phase counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt <= 8'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  // Compute each channel's target and its next level. The target is
  // recomputed every cycle, so a max_level change redirects a ramp that
  // is already in progress.
  always_comb begin
    w_target     = '0;
    w_level_next = r_level;
    for (int i = 0; i < 4; i++) begin
      if (r_led_q[i]) begin
        w_target[i] = max_level;
      end else begin
        w_target[i] = 8'd0;
      end
      if (w_tick) begin
        w_level_next[i] = fade_next(r_level[i], w_target[i]);
      end else begin
        w_level_next[i] = r_level[i];
      end
    end
  end

  // Per-channel brightness state. It only moves on a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
    end else begin
      r_level <= w_level_next;
    end
  end

  // Select the output source: PWM of the current level, or the raw
  // registered pattern when bypass is selected.
  always_comb begin
    w_pwm_out  = 4'b0000;
    w_out_next = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_pwm_out[i] = pwm_bit(r_level[i], r_pwm_cnt);
    end
    if (r_bypass_q) begin
      w_out_next = r_led_q;
    end else begin
      w_out_next = w_pwm_out;
    end
  end

  // Registered pin drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led_out <= 4'b0000;
    end else begin
      r_led_out <= w_out_next;
    end
  end

  assign led_out = r_led_out;
  assign level   = r_level;

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed scenarios followed by a randomized run. Every
// cycle is checked against a reference model. The model tracks time as
// "cycles since reset". The fade tick falls where that count mod 4 is 3,
// and the PWM phase is that count mod 256. Brightness moves by min/max
// clamping toward the target.
module tb_led_fader;

  localparam int T    = 4;
  localparam int STEP = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  led_in;
  logic [7:0]  max_level;
  logic        bypass;
  logic [3:0]  led_out;
  logic [31:0] level;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int         m_n;
  int         m_lvl [4];
  logic [3:0] m_led_q;
  logic       m_byp_q;
  logic [3:0] m_out;

  // Log of level changes on one chosen channel.
  int log_ch;
  int log_prev;
  int chg_q [$];

  led_fader #(.FADE_TICK_CYCLES(T), .FADE_STEP(STEP)) dut (
    .clk      (clk),
    .rst      (rst),
    .led_in   (led_in),
    .max_level(max_level),
    .bypass   (bypass),
    .led_out  (led_out),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [3:0] nout;
    int         tgt;
    int         ph;
    if (rst) begin
      m_n = 0;
      m_led_q = 4'b0000;
      m_byp_q = 1'b0;
      m_out = 4'b0000;
      for (int i = 0; i < 4; i++) m_lvl[i] = 0;
    end else begin
      ph = m_n % 256;
      for (int i = 0; i < 4; i++)
        nout[i] = m_byp_q ? m_led_q[i] : ((m_lvl[i] == 255) || (ph < m_lvl[i]));
      if ((m_n % T) == T - 1) begin
        for (int i = 0; i < 4; i++) begin
          tgt = m_led_q[i] ? int'(max_level) : 0;
          if (m_lvl[i] < tgt)      m_lvl[i] = (m_lvl[i] + STEP > tgt) ? tgt : m_lvl[i] + STEP;
          else if (m_lvl[i] > tgt) m_lvl[i] = (m_lvl[i] - STEP < tgt) ? tgt : m_lvl[i] - STEP;
        end
      end
      m_out   = nout;
      m_led_q = led_in;
      m_byp_q = bypass;
      m_n++;
    end
  endtask

  // Advance one clock, update the model, and check both outputs.
  task automatic step();
    logic [31:0] exp_lvl;
    int          cur;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 4; i++) exp_lvl[8*i +: 8] = 8'(m_lvl[i]);
    check("level", level, exp_lvl);
    check("led_out", {28'd0, led_out}, {28'd0, m_out});
    cur = int'(level[8*log_ch +: 8]);
    if (cur != log_prev) chg_q.push_back(cur);
    log_prev = cur;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic start_log(input int ch);
    log_ch   = ch;
    log_prev = int'(level[8*ch +: 8]);
    chg_q.delete();
  endtask

  task automatic check_seq(input string tag, input int n, input int e0, input int e1,
                           input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    check({tag, "_len"}, 32'(chg_q.size()), 32'(n));
    for (int k = 0; k < n; k++)
      if (k < chg_q.size()) check({tag, "_val"}, 32'(chg_q[k]), 32'(e[k]));
  endtask

  task automatic count_high(input string tag, input int exp);
    int hi;
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      hi += int'(led_out[0]);
    end
    check(tag, 32'(hi), 32'(exp));
  endtask

  initial begin
    log_ch = 0;
    log_prev = 0;
    rst = 1'b1; led_in = 4'hF; max_level = 8'd255; bypass = 1'b0;
    // Reset held for three cycles.
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_out", {28'd0, led_out}, 32'd0);
      check("rst_level", level, 32'd0);
    end
    // Release reset. The level holds at 0 until the first tick.
    rst = 1'b0; led_in = 4'b0001;
    start_log(0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("pre_tick_level", level, 32'd0);
    end
    run(37);
    check_seq("ramp_up", 4, 64, 128, 192, 255);
    check("ramp_up_others", {8'd0, level[31:8]}, 32'd0);

    // Ramp down saturates at 0 and never wraps.
    led_in = 4'b0000;
    start_log(0);
    run(30);
    check_seq("ramp_down", 4, 191, 127, 63, 0);
    check("ramp_down_floor", {24'd0, level[7:0]}, 32'd0);

    // Ceiling, then a redirect to a lower ceiling.
    led_in = 4'b0010; max_level = 8'd100;
    start_log(1);
    run(20);
    check_seq("ceiling", 2, 64, 100, 0, 0);
    max_level = 8'd30;
    start_log(1);
    run(20);
    check_seq("redirect", 2, 36, 30, 0, 0);

    // PWM duty at two steady levels.
    led_in = 4'b0001; max_level = 8'd128;
    run(40);
    count_high("duty_128", 128);
    max_level = 8'd1;
    run(20);
    count_high("duty_1", 1);

    // Bypass latency: two cycles from led_in to led_out.
    bypass = 1'b1; led_in = 4'h0;
    run(4);
    led_in = 4'hA;
    step();
    check("byp_lat1", {28'd0, led_out}, 32'd0);
    step();
    check("byp_lat2", {28'd0, led_out}, 32'hA);

    // Reset during an active ramp, then restart the ramp from 0.
    bypass = 1'b0; led_in = 4'hF; max_level = 8'd255;
    run(6);
    rst = 1'b1;
    step();
    check("midrst_level", level, 32'd0);
    check("midrst_out", {28'd0, led_out}, 32'd0);
    rst = 1'b0;
    start_log(0);
    run(20);
    check_seq("restart", 4, 64, 128, 192, 255);

    // Randomized stimulus against the model.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 9) == 0) led_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) max_level = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) bypass = ~bypass;
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_fader.md
# led_fader

Output stage that sits directly downstream of the LED pattern generator and drives the LED pins. Takes the generator's 4-bit on/off pattern and fades each LED smoothly toward its commanded state with a per-channel brightness ramp. Each channel's brightness is rendered as 8-bit PWM. A global brightness ceiling sets maximum intensity, and a bypass mode passes the raw pattern through unchanged.

## Interface
Parameters:
- FADE_TICK_CYCLES, 50_000: clk cycles per fade step (1 ms at 50 MHz).
- FADE_STEP, 8: brightness increment/decrement per fade tick (1..255).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- led_in  input  4  on/off pattern from the pattern generator, same clock domain.
- max_level  input  8  brightness target for channels that are on; 0 = dark, 255 = full.
- bypass  input  1  1 = led_out follows led_in directly (fades still tracked internally).
- led_out  output  4  PWM-modulated LED drive, registered.
- level  output  32  packed current brightness, channel i at [8i+7:8i], for debug/verification.

## Operation
- Input register: led_in and bypass are sampled into led_q/bypass_q every cycle.
- Fade tick counter:
  - Runs 0..FADE_TICK_CYCLES-1 and wraps.
  - A one-cycle tick pulse fires on the cycle the counter equals FADE_TICK_CYCLES-1.
- Per-channel target: led_q[i] ? max_level : 0. The target is re-evaluated at every tick, so a max_level change mid-fade redirects the ramp.
- On tick, each channel i updates independently:
  - level < target: level = min(level + FADE_STEP, target).
  - level > target: level = max(level − FADE_STEP, target).
  - level == target: hold.
  - Arithmetic uses 9-bit intermediates. Level never wraps and never overshoots the target.
- PWM counter: 8-bit, free-running, 0..255, wraps to 0, never stalls.
- Output generation:
  - Normal mode: led_out[i] = (level[i] == 255) ? 1 : (pwm_cnt < level[i]).
    - level 0 → constantly off.
    - level 255 → constantly on.
    - Other levels → exactly level[i] high cycles per 256-cycle period.
  - Bypass mode: led_out = led_q. Level ramps continue, so leaving bypass resumes PWM at the current level with no jump to 0.
- Simultaneous events:
  - led_in changes on a tick cycle: the new value takes effect at the next tick, because the target uses the registered led_q.
  - Direction reversal mid-ramp: the next tick moves from the current level toward the new target.
- Reset (rst sampled high at a clk edge, at any time including mid-fade):
  - led_q = 0, bypass_q = 0.
  - Tick counter = 0, pwm_cnt = 0.
  - All levels = 0.
  - led_out = 0.

## Timing
- Reset values: led_out = 4'b0000, level = 32'h0. Both are valid on the first edge with rst high and hold while rst stays high.
- Bypass latency: led_in → led_out is 2 clk cycles (input register, then output register).
- Fade latency:
  - A change on led_in is seen by the first tick at least 1 cycle after it is registered.
  - A full 0→255 ramp takes ceil(255/FADE_STEP) ticks; 32 ticks (≈32 ms) at defaults.
- level output: updates on the cycle after the tick pulse.
- PWM:
  - Period is 256 clk cycles (≈195 kHz).
  - led_out is registered; it reflects the pwm_cnt/level compare from the previous cycle.
- First tick after reset occurs FADE_TICK_CYCLES cycles after rst deasserts.

## Test plan
All scenarios use FADE_TICK_CYCLES=4 and FADE_STEP=64 unless stated otherwise.
- Reset: hold rst=1 for 3 cycles with led_in=4'hF, max_level=255 → led_out=0 and level=0 on every cycle; after release, level stays 0 until the first tick.
- Ramp up: led_in=4'b0001, max_level=255 → level[7:0] goes 64, 128, 192, 255 on successive ticks, then holds. led_out[0] is constant 1 once level is 255. Channels 1–3 stay 0.
- Ramp down with saturation: from level 255, set led_in=0 → 191, 127, 63, 0, then holds at 0. Never wraps to 255.
- Ceiling and redirect: led_in=4'b0010, max_level=100 → 64, 100, hold. Then max_level=30 → next tick gives 36, following tick gives 30.
- PWM duty: force level 128 (steady state with max_level=128) and count led_out[0] over 256 consecutive cycles → exactly 128 high. Repeat at max_level=1 → exactly 1 high.
- Bypass and reset mid-fade:
  - bypass=1, toggle led_in 0→4'hA → led_out=4'hA exactly 2 cycles later.
  - Assert rst during an active ramp → level=0 and led_out=0 on the next edge, and the ramp restarts from 0 after release.
